mul_issue_ctrl: RTL and testbench
=================================

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32, max WAIT cycles before abort (legal 18..255).
REQ-002 Port clk  input  1  single clock; all state on posedge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  operand pair offered.
REQ-005 Port in_ready  output  1  controller can accept operands.
REQ-006 Port in_a, in_b  input  8 each  signed two's-complement operands.
REQ-007 Port in_acc_clr  input  1  sampled with operands; clears accumulator before adding (MUL_ACC_EN only).
REQ-008 Port mul_a, mul_b  output  8 each  operands to downstream multiplier; held stable from CLEAR through DONE.
REQ-009 Port mul_clr  output  1  one-cycle clear/start pulse to multiplier reset input.
REQ-010 Port mul_p  input  16  multiplier product.
REQ-011 Port mul_rdy  input  1  multiplier done (level, stays high until next mul_clr).
REQ-012 Port out_valid  output  1  result available.
REQ-013 Port out_ready  input  1  consumer accepts result.
REQ-014 Port out_p  output  16  captured product.
REQ-015 Port out_err  output  1  result is a timeout abort; qualified by out_valid.
REQ-016 Port out_acc  output  24  signed running sum of products.

Function
REQ-017 FSM states IDLE, CLEAR, WAIT, DONE; encoding registered.
REQ-018 IDLE: in_ready=1; in_valid high at edge -> latch in_a/in_b/in_acc_clr, go CLEAR.
REQ-019 CLEAR: exactly one cycle, mul_clr=1, timeout counter zeroed, go WAIT; in_ready=0.
REQ-020 WAIT: mul_clr=0; counter increments each cycle; mul_rdy high -> out_p<=mul_p, out_err<=0, go DONE.
REQ-021 WAIT: counter reaching TIMEOUT_CYCLES-1 with mul_rdy low -> out_p<=0, out_err<=1, go DONE; mul_rdy wins if both same cycle.
REQ-022 DONE: out_valid=1, out_p/out_err stable; out_ready high at edge -> go IDLE; in_ready stays 0 (no accept in DONE).
REQ-023 Minimum latency in accept to out_valid = 2 + multiplier cycles; with a 17-cycle multiplier, out_valid first high 19 cycles after accept edge.
REQ-024 mul_rdy ignored outside WAIT; stale rdy from previous op cannot complete a new op.
REQ-025 out_p is sign-preserving: 16-bit product passed unmodified.

Reset
REQ-026 reset asserted: state=IDLE, in_ready=1, mul_clr=1 (multiplier held cleared), out_valid=0, out_err=0, out_p=0, out_acc=0, mul_a=mul_b=0, counter=0.
REQ-027 reset mid-operation (any state) aborts immediately; no result emitted; first post-reset cycle in_ready=1, mul_clr=0.

Configuration
REQ-028 Macro MUL_ISSUE_ACC_EN defined: on successful capture out_acc <= (in_acc_clr latched ? 0 : out_acc) + sign-extended mul_p, wrapping modulo 2^24; timeouts leave out_acc unchanged.
REQ-029 Macro undefined: out_acc tied to 0, in_acc_clr ignored, no accumulator flops.

Structure
REQ-030 Package mul_ctrl_pkg holds state enum, OPW=8, PW=16, ACCW=24, default TIMEOUT_CYCLES.
REQ-031 One sub-module mul_ctrl_timer: 8-bit counter with clear, enable, terminal-count output.

Verification (behavioural 17-cycle multiplier model)
REQ-032 reset, in_a=3, in_b=-2 accepted -> mul_clr one pulse, out_valid after 19 cycles, out_p=0xFFFA, out_err=0.
REQ-033 in_a=-128, in_b=-128 -> out_p=0x4000; out_ready held low 5 cycles -> out_valid/out_p stable, in_ready=0 throughout.
REQ-034 model never asserts mul_rdy -> out_valid after 1+1+TIMEOUT_CYCLES cycles, out_err=1, out_p=0.
REQ-035 MUL_ISSUE_ACC_EN: ops (100,100),(100,100) then (2,3) with in_acc_clr=1 -> out_acc 10000, 20000, 6.
REQ-036 reset pulsed during WAIT -> out_valid never rises for aborted op; next op 5*5 -> out_p=25.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared types and widths for the multiplier issue controller.
package mul_ctrl_pkg;
  localparam int OPW         = 8;
  localparam int PW          = 16;
  localparam int ACCW        = 24;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_DONE
  } state_e;
endpackage

// File: rtl/mul_ctrl_timer.sv
// 8-bit wait counter with clear, enable and terminal-count flag.
module mul_ctrl_timer #(
  parameter logic [7:0] TC = 8'd32
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == TC);
endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/complete controller for an external multi-cycle multiplier.
// Optional accumulator enabled by defining MUL_ISSUE_ACC_EN.
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_a,
  input  logic [OPW-1:0]  in_b,
  input  logic            in_acc_clr,
  output logic [OPW-1:0]  mul_a,
  output logic [OPW-1:0]  mul_b,
  output logic            mul_clr,
  input  logic [PW-1:0]   mul_p,
  input  logic            mul_rdy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   out_p,
  output logic            out_err,
  output logic [ACCW-1:0] out_acc
);
  state_e          state_q, state_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]   p_q, p_d;
  logic            err_q, err_d;
  logic            cap, aclr_in, tc;

  // Timer runs one cycle past TIMEOUT_CYCLES-1 so the abort lands on
  // the same edge count as CLEAR + TIMEOUT_CYCLES waits + capture.
  mul_ctrl_timer #(.TC(8'(TIMEOUT_CYCLES))) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == S_CLEAR),
    .en    (state_q == S_WAIT),
    .tc    (tc)
  );

  assign aclr_in = in_acc_clr;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    err_d   = err_q;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_rdy) begin
          p_d     = mul_p;
          err_d   = 1'b0;
          cap     = 1'b1;
          state_d = S_DONE;
        end else if (tc) begin
          p_d     = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

`ifdef MUL_ISSUE_ACC_EN
  logic            aclr_q, aclr_d;
  logic [ACCW-1:0] acc_q, acc_d;

  always_comb begin
    aclr_d = aclr_q;
    acc_d  = acc_q;
    if (state_q == S_IDLE && in_valid) aclr_d = aclr_in;
    if (cap)
      acc_d = (aclr_q ? '0 : acc_q)
            + {{(ACCW-PW){mul_p[PW-1]}}, mul_p};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aclr_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      aclr_q <= aclr_d;
      acc_q  <= acc_d;
    end
  end

  assign out_acc = acc_q;
`else
  logic unused_acc;
  assign unused_acc = aclr_in ^ cap;
  assign out_acc    = '0;
`endif

  // Multiplier is held cleared for the whole reset as well.
  assign mul_clr   = reset | (state_q == S_CLEAR);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign out_p     = p_q;
  assign out_err   = err_q;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a 17-cycle multiplier model.
module tb_mul_issue_ctrl;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        in_acc_clr = 1'b0;
  logic [7:0]  mul_a, mul_b;
  logic        mul_clr;
  logic [15:0] mul_p;
  logic        mul_rdy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_p;
  logic        out_err;
  logic [23:0] out_acc;

  int checks = 0;
  int passes = 0;
  bit dead = 1'b0;

  mul_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc_clr(in_acc_clr),
    .mul_a(mul_a), .mul_b(mul_b), .mul_clr(mul_clr),
    .mul_p(mul_p), .mul_rdy(mul_rdy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_err(out_err), .out_acc(out_acc)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: rdy rises 17 clocks after the clear pulse.
  int mcnt = 0;
  always @(posedge clk) begin
    if (mul_clr) begin
      mcnt    <= 1;
      mul_rdy <= 1'b0;
      mul_p   <= '0;
    end else if (!mul_rdy && !dead) begin
      if (mcnt == 17) begin
        mul_rdy <= 1'b1;
        mul_p   <= 16'($signed(mul_a) * $signed(mul_b));
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Issue one op; returns cycles from accept edge to out_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic aclr, output int cyc,
                        output int clr_pulses, output bit rdy_low);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_acc_clr = aclr;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 1; clr_pulses = 0; rdy_low = 1'b1;
    while (!out_valid && cyc < 300) begin
      if (mul_clr) clr_pulses++;
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk);
      #1 cyc++;
    end
    cyc--;
    if (!out_valid) check("op_timeout_bound", 0, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("in_ready_after_done", in_ready, 1);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[7];
  int   cyc, np;
  bit   rl;
  logic [15:0] held;

  initial begin
    vecs[0] = '{8'd3,   8'hFE, 16'hFFFA};
    vecs[1] = '{8'h80,  8'h80, 16'h4000};
    vecs[2] = '{8'd127, 8'd127, 16'h3F01};
    vecs[3] = '{8'h80,  8'd127, 16'hC080};
    vecs[4] = '{8'd0,   8'hFB, 16'h0000};
    vecs[5] = '{8'hFF,  8'hFF, 16'h0001};
    vecs[6] = '{8'd5,   8'd5,  16'd25};

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_mul_clr", mul_clr, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_mul_ab", {mul_a, mul_b}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("post_rst_mul_clr", mul_clr, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, cyc, np, rl);
      check($sformatf("v%0d_latency", i), cyc, 19);
      check($sformatf("v%0d_clr_pulses", i), np, 1);
      check($sformatf("v%0d_in_ready_low", i), rl, 1);
      check($sformatf("v%0d_out_p", i), out_p, vecs[i].p);
      check($sformatf("v%0d_out_err", i), out_err, 0);
      check($sformatf("v%0d_mul_ab", i), {mul_a, mul_b},
            {vecs[i].a, vecs[i].b});
      consume();
    end

    // Result held under backpressure.
    run_op(8'h80, 8'h80, 1'b0, cyc, np, rl);
    held = out_p;
    check("bp_out_p", held, 16'h4000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_p_stable", out_p, 16'h4000);
      check("bp_in_ready", in_ready, 0);
    end
    consume();

    // Multiplier never answers: timeout abort.
    dead = 1'b1;
    run_op(8'd9, 8'd9, 1'b0, cyc, np, rl);
    check("to_latency", cyc, 2 + TO);
    check("to_err", out_err, 1);
    check("to_p", out_p, 0);
    consume();
    dead = 1'b0;

    // Reset during WAIT aborts the op.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("midrst_mul_clr", mul_clr, 1);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    #1 check("midrst_post_clr", mul_clr, 0);
    check("midrst_post_ready", in_ready, 1);
    np = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 if (out_valid) np++;
    end
    check("midrst_no_valid", np, 0);
    run_op(8'd5, 8'd5, 1'b0, cyc, np, rl);
    check("midrst_next_p", out_p, 16'd25);
    check("midrst_next_lat", cyc, 19);
    consume();

`ifdef MUL_ISSUE_ACC_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_op(8'd100, 8'd100, 1'b0, cyc, np, rl);
    check("acc_1", out_acc, 24'd10000);
    consume();
    run_op(8'd100, 8'd100, 1'b0, cyc, np, rl);
    check("acc_2", out_acc, 24'd20000);
    consume();
    dead = 1'b1;
    run_op(8'd1, 8'd1, 1'b1, cyc, np, rl);
    check("acc_timeout_keep", out_acc, 24'd20000);
    consume();
    dead = 1'b0;
    run_op(8'd2, 8'd3, 1'b1, cyc, np, rl);
    check("acc_clr", out_acc, 24'd6);
    consume();
    run_op(8'hFF, 8'd10, 1'b0, cyc, np, rl);
    check("acc_neg", out_acc, 24'hFFFFFC);
    consume();
`else
    run_op(8'd2, 8'd3, 1'b1, cyc, np, rl);
    check("acc_tied", out_acc, 0);
    consume();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
